watch_time_setter: RTL and testbench
====================================

// Module: watch_time_setter
// PURPOSE
//  Button-driven time-set controller; the write-side counterpart of the watch counter chain.
//  - Captures the watch's live BCD digits and freezes the watch via hold.
//  - Lets the user step hours, then minutes, with one increment button.
//  - Presents the edited digits with a one-cycle load strobe so the watch counters preload them.
//  - Drives blink/field-select flags for the display block.
// PARAMETERS
//  BLINK_DIV  25_000_000  clk cycles per blink half-period (>=2)
//  HOUR_MIN   1           lowest legal hour value (binary)
//  HOUR_MAX   12          highest legal hour value (binary, <=19)
// PORTS
//  clk       in   1  single system clock, rising edge
//  reset     in   1  synchronous, active-high reset
//  set_req   in   1  set/advance button, clean level; rising edge acts
//  inc       in   1  increment button, clean level; rising edge acts
//  cancel    in   1  abort edit, level; sampled every cycle
//  cur_hr1   in   4  live watch hour tens (BCD)
//  cur_hr0   in   4  live watch hour units (BCD)
//  cur_min1  in   4  live watch minute tens (BCD)
//  cur_min0  in   4  live watch minute units (BCD)
//  hr1,hr0   out  4  edit-buffer hour digits (BCD)
//  min1,min0 out  4  edit-buffer minute digits (BCD)
//  load      out  1  one-cycle strobe: watch preloads hr1..min0
//  hold      out  1  1 = watch counters frozen (drives watch stop)
//  edit_hr   out  1  hour field selected
//  edit_min  out  1  minute field selected
//  blink     out  1  display blink phase, 0 outside edit
// BEHAVIOUR
//  Reset:
//   - state=RUN; all digit outputs 0; load, hold, edit_hr, edit_min, blink = 0; blink counter 0.
//   - Edge-history regs for set_req/inc reset to 1, so a button held through reset does not fire.
//  Edge detect: edge = in & ~in_q; in_q = in delayed 1 clk. Transition at the same clk edge.
//  FSM:
//   - RUN -> CAPTURE on set_req edge; inc ignored in RUN.
//   - CAPTURE (1 cycle): copy cur_* into buffer, hold=1, blink=1, counter=0 -> EDIT_HR.
//     Captured hour not valid BCD or outside HOUR_MIN..HOUR_MAX -> clamp to HOUR_MIN.
//     Captured minute not valid BCD or >59 -> 00.
//   - EDIT_HR: edit_hr=1. inc edge: hour+1, HOUR_MAX wraps to HOUR_MIN. set_req edge -> EDIT_MIN.
//   - EDIT_MIN: edit_min=1. inc edge: minute+1, 59 wraps to 00, no carry into hour. set_req edge -> COMMIT.
//   - COMMIT (1 cycle): load=1, hold=1 -> RUN; hold drops the cycle after load.
//  Priority in edit states: cancel > set_req edge > inc edge; lower ones dropped the same cycle.
//  cancel=1 in CAPTURE/EDIT_*: -> RUN next edge, no load, hold=0, buffer kept. cancel ignored in RUN/COMMIT.
//  Arithmetic:
//   - Buffer held as BCD digit pairs; increment is BCD (x9 -> (x+1)0).
//   - Hour compare done on value 10*hr1+hr0.
//  Blink:
//   - In EDIT_*, counter runs 0..BLINK_DIV-1; blink toggles on wrap.
//   - Counter restarts at 0 and blink=1 on any inc edge, so the edited field stays visible.
//   - blink=0 in RUN.
//  Buffer outputs hold last value in RUN; they are meaningful only when load=1.
//  Reset asserted mid-edit aborts immediately: no load, hold=0.
// STRUCTURE
//  Shared include watch_defs.vh:
//   - State encodings RUN/CAPTURE/EDIT_HR/EDIT_MIN/COMMIT.
//   - BCD_MAX_MIN1=5, BCD_MAX_DIGIT=9.
//  Sub-module btn_edge (rising-edge detector, reset-to-1 history), instantiated for set_req and inc.
//  FSM, BCD incrementers, clamp logic and blink divider stay in this module.
// TESTING (BLINK_DIV=4 for sim)
//  1. Reset with set_req held 1, then release -> no state change; all outputs 0.
//  2. cur=11:58; set_req, 2x inc, set_req, 3x inc, set_req -> load pulse 1 cycle, hr=01, min=01, hold 1->0 after load.
//  3. EDIT_MIN at 59, inc -> 00, hour unchanged; EDIT_HR at 12, inc -> 01.
//  4. cur_hr=1,5 (invalid), cur_min=7,3 -> capture gives hr=01, min=00.
//  5. set_req and inc edges same cycle in EDIT_HR -> EDIT_MIN, hour unchanged; cancel in EDIT_MIN -> RUN, load never 1, hold=0.
//  6. Idle 10 cycles in EDIT_HR -> blink toggles every 4 cycles starting 1; inc restarts phase; RUN -> blink=0.

Source files
------------

// File: rtl/watch_time_setter_pkg.sv
// Shared types and BCD helpers for the watch time-set controller.
package watch_time_setter_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_CAPTURE,
        ST_EDIT_HR,
        ST_EDIT_MIN,
        ST_COMMIT
    } state_t;

    localparam logic [3:0] BCD_MAX_MIN1  = 4'd5;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    typedef struct packed {
        logic [3:0] d1;
        logic [3:0] d0;
    } bcd2_t;

    function automatic logic [7:0] bcd2_val(input bcd2_t b);
        return 8'(b.d1) * 8'd10 + 8'(b.d0);
    endfunction

    function automatic logic bcd2_valid(input bcd2_t b);
        return (b.d1 <= BCD_MAX_DIGIT) && (b.d0 <= BCD_MAX_DIGIT);
    endfunction

    function automatic bcd2_t bcd2_inc(input bcd2_t b);
        bcd2_t r;
        if (b.d0 >= BCD_MAX_DIGIT) begin
            r.d1 = b.d1 + 4'd1;
            r.d0 = 4'd0;
        end else begin
            r.d1 = b.d1;
            r.d0 = b.d0 + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd2_t to_bcd2(input logic [7:0] v);
        bcd2_t r;
        r.d1 = 4'(v / 8'd10);
        r.d0 = 4'(v % 8'd10);
        return r;
    endfunction

endpackage

// File: rtl/watch_time_setter_btn_edge.sv
// Rising-edge detector; history resets to 1 so a button held through reset never fires.
module watch_time_setter_btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);
    logic btn_q;

    always_ff @(posedge clk) begin
        if (reset) btn_q <= 1'b1;
        else       btn_q <= btn;
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/watch_time_setter.sv
// Button-driven time-set controller: capture live time, step hours then minutes, strobe load.
module watch_time_setter
    import watch_time_setter_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000,
    parameter int HOUR_MIN  = 1,
    parameter int HOUR_MAX  = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_req,
    input  logic       inc,
    input  logic       cancel,
    input  logic [3:0] cur_hr1,
    input  logic [3:0] cur_hr0,
    input  logic [3:0] cur_min1,
    input  logic [3:0] cur_min0,
    output logic [3:0] hr1,
    output logic [3:0] hr0,
    output logic [3:0] min1,
    output logic [3:0] min0,
    output logic       load,
    output logic       hold,
    output logic       edit_hr,
    output logic       edit_min,
    output logic       blink
);
    localparam int          CNT_W      = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [7:0]  HMIN       = 8'(HOUR_MIN);
    localparam logic [7:0]  HMAX       = 8'(HOUR_MAX);
    localparam bcd2_t       HR_MIN_BCD = to_bcd2(HMIN);

    // Bit 0 = set_req, bit 1 = inc.
    logic [1:0] btn_lvl, btn_rise;
    logic       set_e, inc_e;

    assign btn_lvl = {inc, set_req};

    watch_time_setter_btn_edge u_btn_edge [1:0] (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_lvl),
        .rise  (btn_rise)
    );

    assign set_e = btn_rise[0];
    assign inc_e = btn_rise[1];

    state_t           state;
    bcd2_t            hr_buf, min_buf;
    logic [CNT_W-1:0] blink_cnt;

    bcd2_t      cur_hr, cur_min, cap_hr, cap_min, hr_inc, min_inc;
    logic [7:0] cur_hr_val;

    assign cur_hr     = {cur_hr1, cur_hr0};
    assign cur_min    = {cur_min1, cur_min0};
    assign cur_hr_val = bcd2_val(cur_hr);

    // Out-of-range live values are normalised so the edit buffer is always legal.
    assign cap_hr  = (bcd2_valid(cur_hr) && cur_hr_val >= HMIN && cur_hr_val <= HMAX)
                     ? cur_hr : HR_MIN_BCD;
    assign cap_min = (bcd2_valid(cur_min) && cur_min.d1 <= BCD_MAX_MIN1) ? cur_min : bcd2_t'(8'h00);

    assign hr_inc  = (bcd2_val(hr_buf) >= HMAX) ? HR_MIN_BCD : bcd2_inc(hr_buf);
    assign min_inc = (min_buf.d1 >= BCD_MAX_MIN1 && min_buf.d0 >= BCD_MAX_DIGIT)
                     ? bcd2_t'(8'h00) : bcd2_inc(min_buf);

    assign hr1  = hr_buf.d1;
    assign hr0  = hr_buf.d0;
    assign min1 = min_buf.d1;
    assign min0 = min_buf.d0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            hr_buf    <= '0;
            min_buf   <= '0;
            load      <= 1'b0;
            hold      <= 1'b0;
            edit_hr   <= 1'b0;
            edit_min  <= 1'b0;
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else begin
            load <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (set_e) begin
                        state <= ST_CAPTURE;
                        hold  <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (cancel) begin
                        state <= ST_RUN;
                        hold  <= 1'b0;
                    end else begin
                        hr_buf    <= cap_hr;
                        min_buf   <= cap_min;
                        blink     <= 1'b1;
                        blink_cnt <= '0;
                        edit_hr   <= 1'b1;
                        state     <= ST_EDIT_HR;
                    end
                end
                ST_EDIT_HR, ST_EDIT_MIN: begin
                    // Free-running blink; later assignments below override it.
                    if (blink_cnt == CNT_LAST) begin
                        blink_cnt <= '0;
                        blink     <= ~blink;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end

                    if (cancel) begin
                        state     <= ST_RUN;
                        hold      <= 1'b0;
                        edit_hr   <= 1'b0;
                        edit_min  <= 1'b0;
                        blink     <= 1'b0;
                        blink_cnt <= '0;
                    end else if (set_e) begin
                        if (state == ST_EDIT_HR) begin
                            state    <= ST_EDIT_MIN;
                            edit_hr  <= 1'b0;
                            edit_min <= 1'b1;
                        end else begin
                            state     <= ST_COMMIT;
                            edit_min  <= 1'b0;
                            load      <= 1'b1;
                            blink     <= 1'b0;
                            blink_cnt <= '0;
                        end
                    end else if (inc_e) begin
                        if (state == ST_EDIT_HR) hr_buf  <= hr_inc;
                        else                     min_buf <= min_inc;
                        blink     <= 1'b1;
                        blink_cnt <= '0;
                    end
                end
                ST_COMMIT: begin
                    state <= ST_RUN;
                    hold  <= 1'b0;
                end
                default: begin
                    state <= ST_RUN;
                    hold  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_watch_time_setter.sv
// Directed plus random stimulus against a decimal-arithmetic reference model.
module tb_watch_time_setter;
    localparam int BD   = 4;
    localparam int HMIN = 1;
    localparam int HMAX = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1, set_req = 1'b0, inc = 1'b0, cancel = 1'b0;
    logic [3:0] cur_hr1 = 4'd0, cur_hr0 = 4'd0, cur_min1 = 4'd0, cur_min0 = 4'd0;
    logic [3:0] hr1, hr0, min1, min0;
    logic       load, hold, edit_hr, edit_min, blink;

    watch_time_setter #(.BLINK_DIV(BD), .HOUR_MIN(HMIN), .HOUR_MAX(HMAX)) dut (
        .clk(clk), .reset(reset), .set_req(set_req), .inc(inc), .cancel(cancel),
        .cur_hr1(cur_hr1), .cur_hr0(cur_hr0), .cur_min1(cur_min1), .cur_min0(cur_min0),
        .hr1(hr1), .hr0(hr0), .min1(min1), .min0(min0),
        .load(load), .hold(hold), .edit_hr(edit_hr), .edit_min(edit_min), .blink(blink)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_loads  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Model: mode 0=running 1=capturing 2=hours 3=minutes 4=committing; time kept as integers.
    int m_mode = 0, m_hr = 0, m_min = 0, m_age = 0;
    bit p_set = 1'b1, p_inc = 1'b1;

    task automatic model_step();
        bit se, ie;
        int h, m;
        se = set_req && !p_set;
        ie = inc && !p_inc;
        p_set = set_req;
        p_inc = inc;
        if (reset) begin
            m_mode = 0; m_hr = 0; m_min = 0; m_age = 0;
            p_set = 1'b1; p_inc = 1'b1;
            return;
        end
        case (m_mode)
            0: if (se) m_mode = 1;
            1: begin
                if (cancel) m_mode = 0;
                else begin
                    h = 10 * int'(cur_hr1) + int'(cur_hr0);
                    m = 10 * int'(cur_min1) + int'(cur_min0);
                    m_hr  = (cur_hr1 <= 9 && cur_hr0 <= 9 && h >= HMIN && h <= HMAX) ? h : HMIN;
                    m_min = (cur_min1 <= 9 && cur_min0 <= 9 && m <= 59) ? m : 0;
                    m_mode = 2;
                    m_age  = 0;
                end
            end
            2, 3: begin
                m_age++;
                if (cancel) m_mode = 0;
                else if (se) m_mode = (m_mode == 2) ? 3 : 4;
                else if (ie) begin
                    if (m_mode == 2) m_hr = (m_hr == HMAX) ? HMIN : m_hr + 1;
                    else             m_min = (m_min == 59) ? 0 : m_min + 1;
                    m_age = 0;
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic tick();
        int eb;
        @(posedge clk);
        model_step();
        #1;
        eb = ((m_mode == 2 || m_mode == 3) && ((m_age / BD) % 2 == 0)) ? 1 : 0;
        if (load) n_loads++;
        chk("hr1",      int'(hr1),      m_hr / 10);
        chk("hr0",      int'(hr0),      m_hr % 10);
        chk("min1",     int'(min1),     m_min / 10);
        chk("min0",     int'(min0),     m_min % 10);
        chk("load",     int'(load),     (m_mode == 4) ? 1 : 0);
        chk("hold",     int'(hold),     (m_mode != 0) ? 1 : 0);
        chk("edit_hr",  int'(edit_hr),  (m_mode == 2) ? 1 : 0);
        chk("edit_min", int'(edit_min), (m_mode == 3) ? 1 : 0);
        chk("blink",    int'(blink),    eb);
    endtask

    task automatic press_set();
        set_req = 1'b1; tick();
        set_req = 1'b0; tick();
    endtask

    task automatic press_inc();
        inc = 1'b1; tick();
        inc = 1'b0; tick();
    endtask

    task automatic set_cur(input int h1, input int h0, input int m1, input int m0);
        cur_hr1 = 4'(h1); cur_hr0 = 4'(h0); cur_min1 = 4'(m1); cur_min0 = 4'(m0);
    endtask

    initial begin
        // 1: button held through reset must not start an edit
        reset = 1'b1; set_req = 1'b1; inc = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        set_req = 1'b0; inc = 1'b0;
        repeat (2) tick();

        // 2: 11:58 -> two hour steps, three minute steps -> 01:01
        set_cur(1, 1, 5, 8);
        press_set();
        press_inc(); press_inc();
        press_set();
        press_inc(); press_inc(); press_inc();
        n_loads = 0;
        press_set();
        repeat (2) tick();
        chk("load_pulses", n_loads, 1);

        // 3: minute 59 wraps without hour carry; hour 12 wraps to 01
        set_cur(1, 2, 5, 9);
        press_set();
        press_inc();
        press_set();
        press_inc();
        press_set();
        tick();

        // 4: invalid live digits are normalised on capture
        set_cur(1, 5, 7, 3);
        press_set();
        tick();

        // 5: simultaneous set/inc, then cancel in minutes
        set_req = 1'b1; inc = 1'b1; tick();
        set_req = 1'b0; inc = 1'b0; tick();
        n_loads = 0;
        cancel = 1'b1; tick();
        cancel = 1'b0; repeat (3) tick();
        chk("cancel_no_load", n_loads, 0);

        // 6: blink phase while idle, restarted by inc, cleared in run
        set_cur(0, 9, 3, 0);
        press_set();
        repeat (10) tick();
        press_inc();
        repeat (6) tick();
        cancel = 1'b1; tick();
        cancel = 1'b0; repeat (2) tick();

        // mid-edit reset aborts
        press_set();
        reset = 1'b1; tick();
        reset = 1'b0; repeat (2) tick();

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            reset  = ($urandom_range(0, 399) == 0);
            cancel = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 3) == 0) set_req = ~set_req;
            if ($urandom_range(0, 1) == 0) inc = ~inc;
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    set_cur($urandom_range(0, 15), $urandom_range(0, 15),
                            $urandom_range(0, 15), $urandom_range(0, 15));
                else
                    set_cur($urandom_range(0, 1), $urandom_range(0, 9),
                            $urandom_range(0, 5), $urandom_range(0, 9));
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
